// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM on tck rising edges. Scan-chain
// control strobes are re-timed on tck falling edges so gated clocks stay glitch-free.
module jtag_tap_controller (
   input  logic       tck,
   input  logic       trstn,
   input  logic       tms,
   output logic [3:0] tap_state,
   output logic       clockir,
   output logic       shiftir,
   output logic       updateir,
   output logic       clockdr,
   output logic       shiftdr,
   output logic       updatedr,
   output logic       reset_n,
   output logic       select,
   output logic       enable
);

   typedef enum logic [3:0] {
      ST_EX2DR   = 4'h0,
      ST_EX1DR   = 4'h1,
      ST_SHDR    = 4'h2,
      ST_PAUSEDR = 4'h3,
      ST_SELIR   = 4'h4,
      ST_UPDDR   = 4'h5,
      ST_CAPDR   = 4'h6,
      ST_SELDR   = 4'h7,
      ST_EX2IR   = 4'h8,
      ST_EX1IR   = 4'h9,
      ST_SHIR    = 4'hA,
      ST_PAUSEIR = 4'hB,
      ST_RTI     = 4'hC,
      ST_UPDIR   = 4'hD,
      ST_CAPIR   = 4'hE,
      ST_TLR     = 4'hF
   } tap_state_e;

   tap_state_e state_q, state_d;

   logic shiftir_q,  shiftir_d;
   logic shiftdr_q,  shiftdr_d;
   logic updateir_q, updateir_d;
   logic updatedr_q, updatedr_d;
   logic clkir_en_q, clkir_en_d;
   logic clkdr_en_q, clkdr_en_d;
   logic reset_n_q,  reset_n_d;
   logic select_q,   select_d;
   logic enable_q,   enable_d;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge tck or negedge trstn) begin
      if (!trstn) begin
         state_q <= ST_TLR;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_TLR:     state_d = tms ? ST_TLR   : ST_RTI;
         ST_RTI:     state_d = tms ? ST_SELDR : ST_RTI;
         ST_SELDR:   state_d = tms ? ST_SELIR : ST_CAPDR;
         ST_CAPDR:   state_d = tms ? ST_EX1DR : ST_SHDR;
         ST_SHDR:    state_d = tms ? ST_EX1DR : ST_SHDR;
         ST_EX1DR:   state_d = tms ? ST_UPDDR : ST_PAUSEDR;
         ST_PAUSEDR: state_d = tms ? ST_EX2DR : ST_PAUSEDR;
         ST_EX2DR:   state_d = tms ? ST_UPDDR : ST_SHDR;
         ST_UPDDR:   state_d = tms ? ST_SELDR : ST_RTI;
         ST_SELIR:   state_d = tms ? ST_TLR   : ST_CAPIR;
         ST_CAPIR:   state_d = tms ? ST_EX1IR : ST_SHIR;
         ST_SHIR:    state_d = tms ? ST_EX1IR : ST_SHIR;
         ST_EX1IR:   state_d = tms ? ST_UPDIR : ST_PAUSEIR;
         ST_PAUSEIR: state_d = tms ? ST_EX2IR : ST_PAUSEIR;
         ST_EX2IR:   state_d = tms ? ST_UPDIR : ST_SHIR;
         ST_UPDIR:   state_d = tms ? ST_SELDR : ST_RTI;
         default:    state_d = ST_TLR;
      endcase
   end

   always_comb begin
      shiftir_d  = (state_q == ST_SHIR);
      shiftdr_d  = (state_q == ST_SHDR);
      updateir_d = (state_q == ST_UPDIR);
      updatedr_d = (state_q == ST_UPDDR);
      clkir_en_d = (state_q == ST_CAPIR) || (state_q == ST_SHIR);
      clkdr_en_d = (state_q == ST_CAPDR) || (state_q == ST_SHDR);
      reset_n_d  = (state_q != ST_TLR);
      select_d   = state_q inside {ST_SELIR, ST_CAPIR, ST_SHIR, ST_EX1IR,
                                   ST_PAUSEIR, ST_EX2IR, ST_UPDIR};
      enable_d   = (state_q == ST_SHIR) || (state_q == ST_SHDR);
   end

   // Falling-edge retiming keeps the clock enables stable while tck is high.
   always_ff @(negedge tck or negedge trstn) begin
      if (!trstn) begin
         shiftir_q  <= 1'b0;
         shiftdr_q  <= 1'b0;
         updateir_q <= 1'b0;
         updatedr_q <= 1'b0;
         clkir_en_q <= 1'b0;
         clkdr_en_q <= 1'b0;
         reset_n_q  <= 1'b0;
         select_q   <= 1'b0;
         enable_q   <= 1'b0;
      end else begin
         shiftir_q  <= shiftir_d;
         shiftdr_q  <= shiftdr_d;
         updateir_q <= updateir_d;
         updatedr_q <= updatedr_d;
         clkir_en_q <= clkir_en_d;
         clkdr_en_q <= clkdr_en_d;
         reset_n_q  <= reset_n_d;
         select_q   <= select_d;
         enable_q   <= enable_d;
      end
   end

   assign tap_state = state_q;
   assign clockir   = tck & clkir_en_q;
   assign clockdr   = tck & clkdr_en_q;
   assign shiftir   = shiftir_q;
   assign shiftdr   = shiftdr_q;
   assign updateir  = updateir_q;
   assign updatedr  = updatedr_q;
   assign reset_n   = reset_n_q;
   assign select    = select_q;
   assign enable    = enable_q;

endmodule

// File: doc/jtag_tap_controller.md
Name: jtag_tap_controller

Overview:
- IEEE 1149.1 TAP controller: 16-state FSM clocked by tck and steered by tms.
- Drives the control strobes for the downstream instruction register (clockir, shiftir, updateir) and for data registers (clockdr, shiftdr, updatedr).
- Also drives test-logic reset, the IR/DR tdo mux select, and the tdo output enable.
- Sits directly upstream of the instruction register and the boundary/bypass registers.

Parameters:
- None. State encoding is fixed (see Behaviour).

Ports:
- tck  input  1  test clock, the only clock.
- trstn  input  1  asynchronous active-low reset.
- tms  input  1  test mode select, sampled on tck rising edge.
- tap_state  output  4  current FSM state encoding.
- clockir  output  1  gated tck; pulses in Capture-IR and Shift-IR.
- shiftir  output  1  high while in Shift-IR.
- updateir  output  1  rising edge at tck falling edge in Update-IR.
- clockdr  output  1  gated tck; pulses in Capture-DR and Shift-DR.
- shiftdr  output  1  high while in Shift-DR.
- updatedr  output  1  rising edge at tck falling edge in Update-DR.
- reset_n  output  1  test-logic reset, low in Test-Logic-Reset.
- select  output  1  1 = IR path (tdo from IR), 0 = DR path.
- enable  output  1  tdo output enable, high in Shift-IR/Shift-DR.

Behaviour:
- One clock: tck; reset is asynchronous and active-low (trstn). Both edges of tck are used; no other clock.
- State encoding (hex):
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D
- Transitions on tck rising edge (next state for tms=0 / tms=1):
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - SelIR: CapIR / TLR
  - Cap*: Sh* / Ex1*
  - Sh*: Sh* / Ex1*
  - Ex1*: Pause* / Upd*
  - Pause*: Pause* / Ex2*
  - Ex2*: Sh* / Upd*
  - Upd*: RTI / SelDR
- Five consecutive tms=1 rising edges reach TLR from any state.
- Negedge-registered controls, updated on tck falling edge from the current state:
  - shiftir = (ShIR)
  - shiftdr = (ShDR)
  - updateir = (UpdIR)
  - updatedr = (UpdDR)
  - clkir_en = (CapIR | ShIR)
  - clkdr_en = (CapDR | ShDR)
  - reset_n = ~(TLR)
  - select = state in {SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR}
  - enable = (ShIR | ShDR)
- Gated clocks:
  - clockir = tck & clkir_en; clockdr = tck & clkdr_en.
  - Enables change only while tck is low, so the gated clocks are glitch-free.
- Timing consequences:
  - A clockir rising edge occurs on every tck rising edge taken while the state is CapIR or ShIR, including the edge that exits ShIR.
  - updateir rises at the tck falling edge inside UpdIR and stays high one full tck period.
- Reset:
  - trstn low forces tap_state=F immediately, independent of tck.
  - Reset values: shiftir, shiftdr, updateir, updatedr, clkir_en, clkdr_en, select, enable, reset_n = 0.
  - Resulting outputs: clockir = clockdr = 0 regardless of tck.
- Reset mid-operation (e.g. in ShIR): controls drop asynchronously with no further clockir pulse.
- After trstn deasserts, the FSM advances on the next tck rising edge. reset_n goes high at the first falling edge after leaving TLR.
- tms is assumed stable around the tck rising edge; no synchronizer.

Test Plan:
- Reset: trstn=0 with tck toggling → tap_state=F; all controls 0; clockir and clockdr flat. Release trstn, apply tms=0, one rising edge → tap_state=C; reset_n=1 after the following falling edge.
- TLR convergence: from each of the 16 states, 5 tck with tms=1 → tap_state=F; every state reached at least once via legal tms sequences.
- IR scan from RTI:
  - tms sequence 1,1,0,0,0,1,1,0 → states 7,4,E,A,A,9,D,C.
  - Exactly 3 clockir rising edges.
  - shiftir high across the 2 shift edges; select=1 from SelIR through UpdIR.
  - updateir single rise at falling edge in D; enable high only in A.
  - With the 2-bit IR attached, tdi bits 1,0 appear on out1/out2 after updateir.
- DR scan with pause from RTI:
  - tms 1,0,0,0,1,0,0,1,0,0,1,1 → path 7,6,2,2,1,3,3,0,2,2,1,5.
  - clockdr pulses count 5 (capture + 4 shift).
  - clockdr, shiftdr and enable stay low in Pause/Exit states; updatedr one rise in 5; clockir never pulses.
- Async reset mid-shift: in ShIR with tck high, drop trstn → tap_state=F, clockir=0, shiftir=0 without waiting for a tck edge.
- Idle holds: tms=0 in RTI, PauseIR and PauseDR for 10 tck each → state unchanged; no gated-clock or update pulses.
